// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and constants for the one-hot decoder and its encoder twin.
// Holds the FSM state enum, the code/line widths and the onehot_of helper.
package onehot_decoder_seq_pkg;

  localparam int DEC_CODE_W = 3;
  localparam int DEC_OUT_W  = 2 ** DEC_CODE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic logic [DEC_OUT_W-1:0] onehot_of(
    input logic [DEC_CODE_W-1:0] code
  );
    return DEC_OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_dwell.sv
// Loadable down-counter timing how long each one-hot line stays up.
// Ports: clk, rst, load, en, load_val in; zero flag out (count == 0).
module onehot_decoder_seq_dwell #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load wins over en; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder with dwell timing and auto-scan.
// Ports: clk, rst, scan_en, in_valid/in_code/in_ready handshake;
// registered out_onehot, out_code, out_valid, busy.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int CODE_W      = DEC_CODE_W,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scan_en,
  input  logic                   in_valid,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   in_ready,
  output logic [2**CODE_W-1:0]   out_onehot,
  output logic [CODE_W-1:0]      out_code,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int OUT_W = 2 ** CODE_W;
  localparam logic [CNT_W-1:0] RELOAD =
    CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0]  oh_d;
  logic [CODE_W-1:0] code_d;
  logic              load, en, zero;

  onehot_decoder_seq_dwell #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (en),
    .load_val(RELOAD),
    .zero    (zero)
  );

  assign in_ready = (state_q == IDLE) && !scan_en && !rst;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oh_d    = out_onehot;
    code_d  = out_code;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = SCAN;
          idx_d   = '0;
          oh_d    = OUT_W'(1);
          code_d  = '0;
          load    = 1'b1;
        end else if (in_valid) begin
          state_d = HOLD;
          oh_d    = OUT_W'(1) << in_code;
          code_d  = in_code;
          load    = 1'b1;
        end
      end
      HOLD: begin
        if (zero) begin
          state_d = IDLE;
          oh_d    = '0;
          code_d  = '0;
        end else begin
          en = 1'b1;
        end
      end
      SCAN: begin
        if (!scan_en) begin
          // abandon the dwell; next scan restarts at line 0
          state_d = IDLE;
          idx_d   = '0;
          oh_d    = '0;
          code_d  = '0;
        end else if (zero) begin
          idx_d  = idx_q + CODE_W'(1);
          oh_d   = OUT_W'(1) << idx_d;
          code_d = idx_d;
          load   = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        oh_d    = '0;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_onehot <= '0;
      out_code   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_onehot <= oh_d;
      out_code   <= code_d;
      out_valid  <= |oh_d;
      busy       <= (state_d != IDLE);
    end
  end

  a_onehot: assert property (
    @(posedge clk)
    (out_valid == |out_onehot) && $onehot0(out_onehot)
  );

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Sequential binary-to-one-hot decoder: the inverse of the team's 8-to-3 one-hot encoder.
- Accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable dwell time.
- Alternatively auto-scans all lines in order, for display/row multiplexing.
- Output is always all-zero or exactly one-hot, so it loops back cleanly into the encoder.

Parameters:
- CODE_W, 3, code width; OUT_W = 2**CODE_W (8) is derived, not overridable.
- HOLD_CYCLES, 4, cycles each one-hot output is held; legal range 1..255.
- CNT_W, 8, dwell counter width; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- scan_en  input  1  level; requests auto-scan mode.
- in_valid  input  1  code request valid.
- in_code  input  CODE_W  binary code to decode.
- in_ready  output  1  block can accept a code this cycle.
- out_onehot  output  OUT_W  decoded line, registered.
- out_code  output  CODE_W  binary index of the active line (0 when idle).
- out_valid  output  1  high exactly when out_onehot is nonzero.
- busy  output  1  high in HOLD or SCAN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst. It is sampled only at a rising edge.
- Reset values: state=IDLE, out_onehot=0, out_code=0, out_valid=0, busy=0, dwell counter=0, scan index=0.
- Reset mid-operation: rst in any state returns to IDLE at that edge and overrides all other inputs. in_ready is 0 while rst is high.
- States: IDLE, HOLD, SCAN. All outputs come from registers, except in_ready, which is combinational: (state==IDLE) && !scan_en && !rst.
- IDLE:
  - If scan_en=1 at an edge: go to SCAN, out_onehot=1<<0, out_code=0, load dwell=HOLD_CYCLES-1. in_valid is ignored that cycle; scan_en has priority.
  - Else if in_valid && in_ready at an edge: capture in_code and go to HOLD. out_onehot=1<<in_code, out_code=in_code, out_valid=1, dwell=HOLD_CYCLES-1.
  - Handshake latency: one edge. The output is visible in the cycle after acceptance and lasts exactly HOLD_CYCLES cycles.
- HOLD:
  - in_ready=0; scan_en and in_valid are ignored.
  - While dwell!=0, decrement dwell.
  - When dwell==0 at an edge: clear outputs to zero and return to IDLE.
  - Back-to-back requests therefore have one all-zero cycle between pulses. There is no overlap, and never two hot bits.
- SCAN:
  - While scan_en=1 and dwell!=0, decrement dwell.
  - When dwell==0: advance the index (7 wraps to 0), shift out_onehot to the new line, update out_code, reload dwell=HOLD_CYCLES-1.
  - When scan_en=0 at any edge: clear outputs and go to IDLE immediately, abandoning the current dwell. The scan index restarts at 0 on the next entry.
- HOLD_CYCLES=1: one-cycle pulses. In scan, the line advances every cycle.
- Arithmetic: dwell is an unsigned CNT_W-bit counter and never underflows. The scan index is a CODE_W-bit counter with natural wrap.
- in_code is always in range for CODE_W bits. No illegal codes exist, and no X propagation is permitted on out_onehot.
- Invariant, checked by assertion: out_valid == |out_onehot, and $onehot0(out_onehot) always holds.

Decomposition:
- Shared package:
  - state enum {IDLE, HOLD, SCAN} with 2-bit encoding.
  - CODE_W and OUT_W constants, shared with the encoder.
  - Function onehot_of(code), returning 1<<code.
- One sub-module: dwell_counter. It provides a loadable down-counter with a load value input, load and enable strobes, and a zero flag. It is used by both HOLD and SCAN.
- The FSM, output registers and scan index stay in the top module.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> out_onehot=8'h00, out_valid=0, in_ready=1, busy=0.
- Single decode: in_code=3'd5 with in_valid for 1 cycle, HOLD_CYCLES=4 -> out_onehot=8'h20 and out_code=5 for exactly 4 cycles, then 8'h00; in_ready low during those 4 cycles.
- Back-to-back: in_valid held high with codes 0 then 7 -> 8'h01 ×4, one cycle 8'h00, 8'h80 ×4; the second code is accepted only when in_ready=1.
- Scan wrap: scan_en=1 for 36 cycles, HOLD_CYCLES=4 -> sequence 01,02,04,…,80,01, each held 4 cycles; out_code follows 0..7,0.
- Priority and abort: scan_en and in_valid (code 2) both rise in IDLE -> SCAN entered, code not accepted. Drop scan_en mid-dwell -> outputs 0 next cycle, in_ready=1.
- Reset mid-HOLD plus loopback: rst during an 8'h10 pulse -> zero at the next edge. Random codes fed through the 8-to-3 encoder from out_onehot -> recovered code equals in_code on every out_valid cycle.
